// File: rtl/i2c_remap_pkg.sv
// Shared types for the I2C address remapper: FSM states, table entry layout
// and address width.
package i2c_remap_pkg;

   localparam int ADDR_W = 7;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_DATA     = 3'd3,
      S_HOLD     = 3'd4
   } state_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] virt;
      logic [ADDR_W-1:0] phys;
   } remap_entry_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL and SDA into clk, keeps one history sample of each and
// derives the SCL rising edge plus START/STOP conditions.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] line_raw;
   logic [1:0] line_s;
   logic [1:0] line_p_reg;
   logic       scl_s;
   logic       scl_p;
   logic       sda_p;

   assign line_raw = {sda, scl};

   // Chains preset to 1 so the idle-high bus produces no edge out of reset.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic [SYNC_STAGES-1:0] sync_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_reg <= '1;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_raw[gi]};
            end
         end
         assign line_s[gi] = sync_reg[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_p_reg <= '1;
      end else begin
         line_p_reg <= line_s;
      end
   end

   assign scl_s = line_s[0];
   assign sda_s = line_s[1];
   assign scl_p = line_p_reg[0];
   assign sda_p = line_p_reg[1];

   assign scl_rise  = scl_s & ~scl_p;
   assign start_det = sda_p & ~sda_s & scl_s & scl_p;
   assign stop_det  = ~sda_p & sda_s & scl_s & scl_p;

endmodule

// File: rtl/i2c_addr_remap_table.sv
// Passive I2C monitor: captures the address byte of each transfer, remaps it
// through a programmable virtual->physical table and tracks ACK/data phases.
module i2c_addr_remap_table
   import i2c_remap_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int SYNC_STAGES = 2,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              scl,
   input  logic              sda,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_valid,
   input  logic [ADDR_W-1:0] cfg_virt,
   input  logic [ADDR_W-1:0] cfg_phys,
   output logic [ADDR_W-1:0] captured_addr,
   output logic              rw_o,
   output logic [ADDR_W-1:0] translated_addr,
   output logic              translate_hit,
   output logic [IDX_W-1:0]  hit_idx,
   output logic              addr_valid,
   output logic              addr_nack,
   output logic [7:0]        byte_count,
   output logic [2:0]        state_o,
   output logic [3:0]        bitcount_o
);

   logic sda_s;
   logic scl_rise;
   logic start_det;
   logic stop_det;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   remap_entry_t table_q [NUM_ENTRIES];

   // Out-of-range indices match no entry, so such writes fall away naturally.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
         remap_entry_t entry_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               entry_reg <= '0;
            end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
               entry_reg <= {cfg_valid, cfg_virt, cfg_phys};
            end
         end
         assign table_q[gi] = entry_reg;
      end
   endgenerate

   state_t             state_reg, state_next;
   logic [3:0]         bitcount_reg, bitcount_next;
   logic [7:0]         byte_count_reg, byte_count_next;
   logic [ADDR_W-1:0]  shift_reg, shift_next;
   logic               lookup_en;
   logic               nack_next;

   logic [ADDR_W-1:0]  captured_reg;
   logic               rw_reg;
   logic [ADDR_W-1:0]  trans_reg;
   logic               hit_reg;
   logic [IDX_W-1:0]   hit_idx_reg;
   logic               addr_valid_reg;
   logic               addr_nack_reg;

   logic               lk_hit;
   logic [IDX_W-1:0]   lk_idx;
   logic [ADDR_W-1:0]  lk_phys;

   // Scan from the top down so the lowest matching index is the last write.
   always_comb begin
      lk_hit  = 1'b0;
      lk_idx  = '0;
      lk_phys = shift_reg;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (table_q[i].valid && (table_q[i].virt == shift_reg)) begin
            lk_hit  = 1'b1;
            lk_idx  = IDX_W'(i);
            lk_phys = table_q[i].phys;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      bitcount_next   = bitcount_reg;
      byte_count_next = byte_count_reg;
      shift_next      = shift_reg;
      lookup_en       = 1'b0;
      nack_next       = 1'b0;

      if (stop_det) begin
         state_next    = S_IDLE;
         bitcount_next = '0;
      end else if (start_det && ((state_reg != S_IDLE) || enable)) begin
         state_next      = S_ADDR;
         bitcount_next   = '0;
         byte_count_next = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               bitcount_next = '0;
            end
            S_ADDR: begin
               if (scl_rise) begin
                  if (bitcount_reg == 4'd7) begin
                     lookup_en     = 1'b1;
                     state_next    = S_ADDR_ACK;
                     bitcount_next = 4'd8;
                  end else begin
                     shift_next    = {shift_reg[ADDR_W-2:0], sda_s};
                     bitcount_next = bitcount_reg + 4'd1;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_rise) begin
                  bitcount_next = '0;
                  if (sda_s) begin
                     nack_next  = 1'b1;
                     state_next = S_HOLD;
                  end else begin
                     state_next = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (scl_rise) begin
                  if (bitcount_reg == 4'd8) begin
                     bitcount_next = '0;
                     if (byte_count_reg != 8'hFF) begin
                        byte_count_next = byte_count_reg + 8'd1;
                     end
                  end else begin
                     bitcount_next = bitcount_reg + 4'd1;
                  end
               end
            end
            S_HOLD: begin
               bitcount_next = '0;
            end
            default: begin
               state_next    = S_IDLE;
               bitcount_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         bitcount_reg   <= '0;
         byte_count_reg <= '0;
         shift_reg      <= '0;
         captured_reg   <= '0;
         rw_reg         <= 1'b0;
         trans_reg      <= '0;
         hit_reg        <= 1'b0;
         hit_idx_reg    <= '0;
         addr_valid_reg <= 1'b0;
         addr_nack_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bitcount_reg   <= bitcount_next;
         byte_count_reg <= byte_count_next;
         shift_reg      <= shift_next;
         addr_valid_reg <= lookup_en;
         addr_nack_reg  <= nack_next;
         if (lookup_en) begin
            captured_reg <= shift_reg;
            rw_reg       <= sda_s;
            trans_reg    <= lk_phys;
            hit_reg      <= lk_hit;
            hit_idx_reg  <= lk_idx;
         end
      end
   end

   assign captured_addr   = captured_reg;
   assign rw_o            = rw_reg;
   assign translated_addr = trans_reg;
   assign translate_hit   = hit_reg;
   assign hit_idx         = hit_idx_reg;
   assign addr_valid      = addr_valid_reg;
   assign addr_nack       = addr_nack_reg;
   assign byte_count      = byte_count_reg;
   assign state_o         = state_reg;
   assign bitcount_o      = bitcount_reg;

endmodule

// File: tb/tb_i2c_addr_remap_table.sv
// Directed bench for the I2C address remapper; expected lookups are queued by
// the stimulus and checked by a monitor whenever addr_valid pulses.
module tb_i2c_addr_remap_table;

   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       scl;
   logic       sda;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic       cfg_valid;
   logic [6:0] cfg_virt;
   logic [6:0] cfg_phys;
   logic [6:0] captured_addr;
   logic       rw_o;
   logic [6:0] translated_addr;
   logic       translate_hit;
   logic [1:0] hit_idx;
   logic       addr_valid;
   logic       addr_nack;
   logic [7:0] byte_count;
   logic [2:0] state_o;
   logic [3:0] bitcount_o;

   int checks = 0;
   int errors = 0;
   int nack_seen = 0;
   int txn_no = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   i2c_addr_remap_table #(
      .NUM_ENTRIES (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .scl             (scl),
      .sda             (sda),
      .cfg_we          (cfg_we),
      .cfg_idx         (cfg_idx),
      .cfg_valid       (cfg_valid),
      .cfg_virt        (cfg_virt),
      .cfg_phys        (cfg_phys),
      .captured_addr   (captured_addr),
      .rw_o            (rw_o),
      .translated_addr (translated_addr),
      .translate_hit   (translate_hit),
      .hit_idx         (hit_idx),
      .addr_valid      (addr_valid),
      .addr_nack       (addr_nack),
      .byte_count      (byte_count),
      .state_o         (state_o),
      .bitcount_o      (bitcount_o)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [6:0] ca, input logic rw, input logic [6:0] ta,
                           input logic hit, input logic [1:0] idx);
      exp_q.push_back({ca, rw, ta, hit, idx});
   endtask

   // Monitor: one scoreboard comparison per addr_valid pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (addr_valid) begin
            logic [17:0] got;
            logic [17:0] e;
            got = {captured_addr, rw_o, translated_addr, translate_hit, hit_idx};
            txn_no++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_addr_valid actual=0x%0h required=none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL lookup_txn%0d actual addr=%0h rw=%0b trans=%0h hit=%0b idx=%0d required addr=%0h rw=%0b trans=%0h hit=%0b idx=%0d",
                           txn_no, got[17:11], got[10], got[9:3], got[2], got[1:0],
                           e[17:11], e[10], e[9:3], e[2], e[1:0]);
               end else begin
                  $display("txn %0d addr=%0h rw=%0b trans=%0h hit=%0b idx=%0d ok",
                           txn_no, got[17:11], got[10], got[9:3], got[2], got[1:0]);
               end
            end
         end
         if (addr_nack) nack_seen++;
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic v, input logic [6:0] vi,
                            input logic [6:0] ph);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = idx; cfg_valid = v; cfg_virt = vi; cfg_phys = ph;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic i2c_start();
      sda = 1'b1; wclk(Q);
      scl = 1'b1; wclk(Q);
      sda = 1'b0; wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic i2c_stop();
      sda = 1'b0; wclk(Q);
      scl = 1'b1; wclk(Q);
      sda = 1'b1; wclk(Q);
   endtask

   task automatic i2c_bit(input logic b);
      sda = b;    wclk(Q);
      scl = 1'b1; wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic i2c_byte(input logic [7:0] b, input logic ack);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      i2c_bit(ack);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; enable = 1'b1; scl = 1'b1; sda = 1'b1;
      cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_virt = '0; cfg_phys = '0;
      wclk(4);
      check("rst_state", int'(state_o), 0);
      check("rst_outputs", int'({captured_addr, translated_addr, rw_o, translate_hit, hit_idx,
                                  addr_valid, addr_nack, bitcount_o, byte_count}), 0);
      reset = 1'b0;
      wclk(4);

      // Single entry hit, write
      cfg_write(2'd0, 1'b1, 7'h49, 7'h48);
      push_exp(7'h49, 1'b0, 7'h48, 1'b1, 2'd0);
      i2c_start();
      check("t1_state_addr", int'(state_o), 1);
      i2c_byte({7'h49, 1'b0}, 1'b0);
      check("t1_state_data", int'(state_o), 3);
      i2c_stop();
      check("t1_state_idle", int'(state_o), 0);

      // Duplicate virt: lowest index wins, then falls to next after invalidation
      cfg_write(2'd1, 1'b1, 7'h20, 7'h30);
      cfg_write(2'd2, 1'b1, 7'h20, 7'h31);
      push_exp(7'h20, 1'b0, 7'h30, 1'b1, 2'd1);
      i2c_start(); i2c_byte({7'h20, 1'b0}, 1'b0); i2c_stop();
      cfg_write(2'd1, 1'b0, 7'h20, 7'h30);
      push_exp(7'h20, 1'b0, 7'h31, 1'b1, 2'd2);
      i2c_start(); i2c_byte({7'h20, 1'b0}, 1'b0); i2c_stop();

      // Miss, read, NACK -> HOLD until STOP
      push_exp(7'h55, 1'b1, 7'h55, 1'b0, 2'd0);
      i2c_start();
      i2c_byte({7'h55, 1'b1}, 1'b1);
      check("t3_nack_count", nack_seen, 1);
      check("t3_state_hold", int'(state_o), 4);
      i2c_byte(8'h00, 1'b1);
      check("t3_still_hold", int'(state_o), 4);
      check("t3_bytes_hold", int'(byte_count), 0);
      i2c_stop();
      check("t3_state_idle", int'(state_o), 0);

      // Three data bytes then repeated START to a new address
      push_exp(7'h49, 1'b0, 7'h48, 1'b1, 2'd0);
      i2c_start();
      i2c_byte({7'h49, 1'b0}, 1'b0);
      i2c_byte(8'hA5, 1'b0);
      i2c_byte(8'h3C, 1'b1);
      i2c_byte(8'hFF, 1'b0);
      check("t4_byte_count3", int'(byte_count), 3);
      check("t4_bitcount_frame", int'(bitcount_o), 0);
      push_exp(7'h10, 1'b1, 7'h10, 1'b0, 2'd0);
      i2c_start();
      check("t4_rs_byte_clear", int'(byte_count), 0);
      check("t4_rs_state_addr", int'(state_o), 1);
      check("t4_rs_addr_hold", int'(captured_addr), 'h49);
      i2c_byte({7'h10, 1'b1}, 1'b0);
      i2c_stop();

      // enable low blocks a new START; dropping it mid-transfer does not
      enable = 1'b0;
      i2c_start();
      check("t5_disabled_idle", int'(state_o), 0);
      i2c_byte({7'h49, 1'b0}, 1'b0);
      check("t5_disabled_still", int'(state_o), 0);
      i2c_stop();
      enable = 1'b1;
      push_exp(7'h49, 1'b0, 7'h48, 1'b1, 2'd0);
      i2c_start();
      i2c_byte({7'h49, 1'b0}, 1'b0);
      i2c_byte(8'h11, 1'b0);
      enable = 1'b0;
      i2c_byte(8'h22, 1'b0);
      check("t5_bytes_after_disable", int'(byte_count), 2);
      check("t5_state_data", int'(state_o), 3);
      i2c_stop();
      check("t5_state_idle", int'(state_o), 0);
      enable = 1'b1;

      // Reset during bit 4 of the address (SCL low phase)
      i2c_start();
      i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b0); i2c_bit(1'b1);
      sda = 1'b0; wclk(Q);
      reset = 1'b1;
      wclk(3);
      check("t6_rst_state", int'(state_o), 0);
      check("t6_rst_bytecount", int'(byte_count), 0);
      check("t6_rst_lookup", int'({captured_addr, translated_addr, rw_o, translate_hit, hit_idx}), 0);
      check("t6_rst_pulses", int'({addr_valid, addr_nack, bitcount_o}), 0);
      reset = 1'b0;
      wclk(Q);
      scl = 1'b1; wclk(Q);
      scl = 1'b0; wclk(Q);
      i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b0);
      check("t6_no_start_idle", int'(state_o), 0);
      check("t6_no_start_bitcount", int'(bitcount_o), 0);
      i2c_stop();
      push_exp(7'h49, 1'b0, 7'h49, 1'b0, 2'd0);
      i2c_start(); i2c_byte({7'h49, 1'b0}, 1'b0); i2c_stop();

      wclk(10);
      check("end_queue_empty", exp_q.size(), 0);
      check("end_nack_total", nack_seen, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
